// File: rtl/serial_sub.sv
// Bit-serial subtract-with-borrow: r = p - q - bin, one bit per clock, LSB first.
// Result packs WIDTH difference bits under the final borrow (two's-complement sign).
module serial_sub #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   r
);

  localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ACCW = WIDTH - 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [ACCW-1:0]  acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic             done_q, done_d;
  logic             d, br_nx;

  // The accumulator holds only the WIDTH-1 bits already produced; the last
  // difference bit goes straight into r on the completion edge.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    done_d  = 1'b0;
    d       = a_q[0] ^ b_q[0] ^ br_q;
    br_nx   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = p;
          b_d     = q;
          br_d    = bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nx;
        acc_d = ACCW'({d, acc_q} >> 1);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          r_d     = {br_nx, d, acc_q};
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign r    = r_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed corner cases plus a random
// sweep against an integer-arithmetic reference of p - q - bin.
module tb_serial_sub;

  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] p, q;
  logic         bin;
  logic         busy, done;
  logic [W:0]   r;

  int compared = 0;
  int mism     = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .p     (p),
    .q     (q),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .r     (r)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
    int e;
    e = int'(a) - int'(b) - int'(c);
    return e[W:0];
  endfunction

  // Accepts at the next edge, scrambles inputs mid-operation, then waits for done.
  task automatic run_op(input logic [W-1:0] pv, input logic [W-1:0] qv, input logic bv,
                        input logic [W:0] ev, input string tag);
    int lat;
    int bcnt;
    bit seen;
    start = 1'b1; p = pv; q = qv; bin = bv;
    step();
    start = 1'b0; p = W'($urandom); q = W'($urandom); bin = 1'($urandom);
    lat = 0; bcnt = 0; seen = 1'b0;
    while (!seen && lat < 4 * W) begin
      if (busy === 1'b1) bcnt++;
      step();
      lat++;
      seen = (done === 1'b1);
    end
    chk({tag, "_lat"}, lat, W);
    chk({tag, "_busycyc"}, bcnt, W);
    chk({tag, "_r"}, 32'(r), 32'(ev));
    chk({tag, "_busy_at_done"}, 32'(busy), 0);
  endtask

  initial begin
    int ndone;
    int dlat;
    logic [W:0] rhold;

    rst = 1'b1; start = 1'b0; p = '0; q = '0; bin = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_r", 32'(r), 0);
    rst = 1'b0;
    step();

    run_op(5'b10000, 5'b10000, 1'b1, 6'b111111, "neg1");
    rhold = r;
    step();
    chk("done_one_cycle", 32'(done), 0);
    chk("r_hold", 32'(r), 32'(rhold));

    run_op(5'b00111, 5'b00010, 1'b0, 6'b000101, "pos5");
    run_op(5'b00010, 5'b00111, 1'b0, 6'b111011, "neg5");
    run_op(5'b11111, 5'b11110, 1'b1, 6'b000000, "zero");
    run_op(5'b00000, 5'b11111, 1'b1, 6'b100000, "wrap");
    step();

    // Second start while busy must be ignored.
    start = 1'b1; p = 5'b01101; q = 5'b00110; bin = 1'b0;
    step();
    start = 1'b0;
    ndone = 0; dlat = 0;
    for (int i = 1; i <= 2 * W + 2; i++) begin
      if (i == 2) begin
        start = 1'b1; p = 5'b00000; q = 5'b00001;
      end else if (i == 3) begin
        start = 1'b0; p = W'($urandom); q = W'($urandom);
      end
      step();
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) dlat = i;
        chk("ign_r", 32'(r), 32'(6'b000111));
      end
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_lat", dlat, W);

    // Reset mid-operation.
    start = 1'b1; p = 5'b11011; q = 5'b00101; bin = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_r", 32'(r), 0);
    ndone = 0;
    for (int i = 0; i < W + 2; i++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    chk("abort_nodone", ndone, 0);
    run_op(5'b10101, 5'b10001, 1'b0, 6'b000100, "after_rst");
    step();

    // start held high: one result every W+1 cycles.
    start = 1'b1; p = 5'b01100; q = 5'b00110; bin = 1'b0;
    step();
    ndone = 0;
    for (int i = 1; i <= 3 * (W + 1); i++) begin
      step();
      if (done === 1'b1) begin
        ndone++;
        chk("hold_pos", i, ndone * (W + 1) - 1);
        chk("hold_r", 32'(r), 32'(6'b000110));
      end
    end
    chk("hold_ndone", ndone, 3);
    start = 1'b0;
    for (int i = 0; i < 2 * W && busy === 1'b1; i++) step();
    step();

    // Random sweep; consecutive calls also exercise start-in-done-cycle.
    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] pv, qv;
      logic bv;
      pv = W'($urandom);
      qv = W'($urandom);
      bv = 1'($urandom);
      run_op(pv, qv, bv, model(pv, qv, bv), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
